// File: rtl/cnnip_pkg.sv
// Shared types and mode helpers for the CNN IP convolution engine.
package cnnip_pkg;
    localparam int IMG_W = 16;
    localparam int K_MAX = 5;
    localparam int ACC_W = 32;
    localparam int SUM_W = 22;
    localparam int TAPS  = K_MAX * K_MAX;

    typedef enum logic [2:0] {
        IDLE, LOAD_W, MAC, ACC_LAST, WR, DONE
    } conv_state_t;

    function automatic logic mode_legal(
        input logic [7:0] k,
        input logic [1:0] s
    );
        return (k == 8'd1 || k == 8'd3 || k == 8'd5)
            && (s == 2'd1 || s == 2'd2);
    endfunction

    // Stride is 1 or 2 here, so the divide reduces to a shift.
    function automatic logic [4:0] calc_n(
        input logic [2:0] k,
        input logic [1:0] s,
        input logic       pad
    );
        int n;
        if (pad)
            n = (s == 2'd2) ? (IMG_W + 1) / 2 : IMG_W;
        else
            n = (s == 2'd2) ? (IMG_W - int'(k)) / 2 + 1
                            : IMG_W - int'(k) + 1;
        return 5'(n);
    endfunction
endpackage

// File: rtl/cnnip_conv_engine_if.sv
// Memory-side bus of the convolution engine: input, weight and feature ports.
interface cnnip_conv_engine_if;
    import cnnip_pkg::*;

    logic              in_rd_en;
    logic [7:0]        in_addr;
    logic [7:0]        in_rdata;
    logic              w_rd_en;
    logic [4:0]        w_addr;
    logic signed [7:0] w_rdata;
    logic              ft_wr_en;
    logic [7:0]        ft_addr;
    logic [ACC_W-1:0]  ft_wdata;

    modport master (
        output in_rd_en, in_addr, w_rd_en, w_addr,
        output ft_wr_en, ft_addr, ft_wdata,
        input  in_rdata, w_rdata
    );

    modport slave (
        input  in_rd_en, in_addr, w_rd_en, w_addr,
        input  ft_wr_en, ft_addr, ft_wdata,
        output in_rdata, w_rdata
    );
endinterface

// File: rtl/cnnip_mac.sv
// Registered multiply-accumulate: unsigned pixel x signed weight.
module cnnip_mac
    import cnnip_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_clr,
    input  logic                    i_zero,
    input  logic [7:0]              i_pix,
    input  logic signed [7:0]       i_w,
    output logic signed [SUM_W-1:0] o_acc
);
    logic signed [16:0]      w_px;
    logic signed [16:0]      w_wx;
    logic signed [16:0]      w_prod;
    logic signed [SUM_W-1:0] w_base;
    logic signed [SUM_W-1:0] r_acc;

    assign w_px   = 17'($signed({1'b0, i_pix}));
    assign w_wx   = 17'(i_w);
    assign w_prod = i_zero ? '0 : w_px * w_wx;
    assign w_base = i_clr ? '0 : r_acc;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_acc <= '0;
        else if (i_en)
            r_acc <= w_base + SUM_W'(w_prod);
    end

    assign o_acc = r_acc;
endmodule

// File: rtl/cnnip_conv_engine.sv
// Convolution sequencer: weight load, per-pixel tap walk, feature write-back.
module cnnip_conv_engine
    import cnnip_pkg::*;
(
    input  logic       clk_a,
    input  logic       rst_aq,
    input  logic       CONV_start,
    input  logic [7:0] MODE_KERNEL_SIZE,
    input  logic [1:0] MODE_STRIDE,
    input  logic       MODE_PADDING,
    cnnip_conv_engine_if.master mem,
    output logic       CONV_end,
    output logic       CONV_err,
    output logic       busy
);
    conv_state_t r_state;
    logic [2:0] r_k, r_ky, r_kx;
    logic [1:0] r_s, r_p;
    logic [4:0] r_kk, r_n, r_cnt, r_tap;
    logic [3:0] r_ox, r_oy;
    logic       r_in_rd_en, r_w_rd_en, r_ft_wr_en;
    logic [7:0] r_in_addr, r_ft_addr;
    logic [4:0] r_w_addr;
    logic       r_end, r_err, r_busy;
    logic       r_tap_vld, r_tap_zero, r_tap_first;
    logic [4:0] r_tap_widx;
    logic       r_mac_vld, r_mac_zero, r_mac_first;
    logic [4:0] r_mac_widx;
    logic       r_wcap_en;
    logic [4:0] r_wcap_idx;
    logic signed [7:0] r_wrf [0:TAPS-1];

    logic [2:0] w_nky, w_nkx;
    logic [3:0] w_nox, w_noy, w_nm1;
    logic [4:0] w_ntap, w_oys, w_oxs, w_mk;
    logic [6:0] w_iy, w_ix;
    logic [7:0] w_pix_addr;
    logic       w_inb, w_issue, w_last_px;
    logic signed [SUM_W-1:0] w_acc;

    assign w_mk       = {2'b0, MODE_KERNEL_SIZE[2:0]};
    assign w_nm1      = 4'(r_n - 5'd1);
    assign w_last_px  = (r_ox == w_nm1) && (r_oy == w_nm1);
    assign w_pix_addr = {4'b0, r_oy} * {3'b0, r_n} + {4'b0, r_ox};

    always_comb begin
        w_nky   = r_ky;
        w_nkx   = r_kx;
        w_nox   = r_ox;
        w_noy   = r_oy;
        w_ntap  = r_tap + 5'd1;
        w_issue = 1'b0;
        unique case (r_state)
            LOAD_W: begin
                w_nky   = '0;
                w_nkx   = '0;
                w_nox   = '0;
                w_noy   = '0;
                w_ntap  = '0;
                w_issue = (r_cnt == r_kk);
            end
            MAC: begin
                w_issue = (r_tap != r_kk - 5'd1);
                if (r_kx == r_k - 3'd1) begin
                    w_nkx = '0;
                    w_nky = r_ky + 3'd1;
                end else begin
                    w_nkx = r_kx + 3'd1;
                end
            end
            WR: begin
                w_nky   = '0;
                w_nkx   = '0;
                w_ntap  = '0;
                w_issue = !w_last_px;
                if (r_ox == w_nm1) begin
                    w_nox = '0;
                    w_noy = r_oy + 4'd1;
                end else begin
                    w_nox = r_ox + 4'd1;
                end
            end
            default: ;
        endcase
    end

    // Negative (padding) coordinates wrap high, so one unsigned compare
    // covers both edges of the image.
    assign w_oys = (r_s == 2'd2) ? {w_noy, 1'b0} : {1'b0, w_noy};
    assign w_oxs = (r_s == 2'd2) ? {w_nox, 1'b0} : {1'b0, w_nox};
    assign w_iy  = {2'b0, w_oys} + {4'b0, w_nky} - {5'b0, r_p};
    assign w_ix  = {2'b0, w_oxs} + {4'b0, w_nkx} - {5'b0, r_p};
    assign w_inb = (w_iy < 7'(IMG_W)) && (w_ix < 7'(IMG_W));

    always_ff @(posedge clk_a) begin
        if (rst_aq) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_s         <= '0;
            r_p         <= '0;
            r_kk        <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_tap       <= '0;
            r_ky        <= '0;
            r_kx        <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_in_rd_en  <= 1'b0;
            r_in_addr   <= '0;
            r_w_rd_en   <= 1'b0;
            r_w_addr    <= '0;
            r_ft_wr_en  <= 1'b0;
            r_ft_addr   <= '0;
            r_end       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_tap_vld   <= 1'b0;
            r_tap_zero  <= 1'b0;
            r_tap_first <= 1'b0;
            r_tap_widx  <= '0;
        end else begin
            r_in_rd_en <= 1'b0;
            r_w_rd_en  <= 1'b0;
            r_ft_wr_en <= 1'b0;
            r_end      <= 1'b0;
            r_err      <= 1'b0;
            r_tap_vld  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (CONV_start) begin
                        r_busy <= 1'b1;
                        if (mode_legal(MODE_KERNEL_SIZE, MODE_STRIDE)) begin
                            r_k       <= MODE_KERNEL_SIZE[2:0];
                            r_s       <= MODE_STRIDE;
                            r_p       <= MODE_PADDING
                                ? 2'((MODE_KERNEL_SIZE[2:0] - 3'd1) >> 1)
                                : 2'd0;
                            r_kk      <= w_mk * w_mk;
                            r_n       <= calc_n(MODE_KERNEL_SIZE[2:0],
                                                MODE_STRIDE, MODE_PADDING);
                            r_cnt     <= '0;
                            r_w_rd_en <= 1'b1;
                            r_w_addr  <= '0;
                            r_state   <= LOAD_W;
                        end else begin
                            r_end   <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                LOAD_W: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt + 5'd1 < r_kk) begin
                        r_w_rd_en <= 1'b1;
                        r_w_addr  <= r_cnt + 5'd1;
                    end
                    if (r_cnt == r_kk)
                        r_state <= MAC;
                end
                MAC: begin
                    if (r_tap == r_kk - 5'd1)
                        r_state <= ACC_LAST;
                end
                ACC_LAST: begin
                    r_ft_wr_en <= 1'b1;
                    r_ft_addr  <= w_pix_addr;
                    r_state    <= WR;
                end
                WR: begin
                    if (w_last_px) begin
                        r_end   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= MAC;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_issue) begin
                r_ky        <= w_nky;
                r_kx        <= w_nkx;
                r_ox        <= w_nox;
                r_oy        <= w_noy;
                r_tap       <= w_ntap;
                r_in_rd_en  <= w_inb;
                if (w_inb)
                    r_in_addr <= {w_iy[3:0], w_ix[3:0]};
                r_tap_vld   <= 1'b1;
                r_tap_zero  <= !w_inb;
                r_tap_first <= (w_ntap == 5'd0);
                r_tap_widx  <= w_ntap;
            end
        end
    end

    // Read data lands one cycle after the strobe; align tap info with it.
    always_ff @(posedge clk_a) begin
        if (rst_aq) begin
            r_mac_vld   <= 1'b0;
            r_mac_zero  <= 1'b0;
            r_mac_first <= 1'b0;
            r_mac_widx  <= '0;
            r_wcap_en   <= 1'b0;
            r_wcap_idx  <= '0;
        end else begin
            r_mac_vld   <= r_tap_vld;
            r_mac_zero  <= r_tap_zero;
            r_mac_first <= r_tap_first;
            r_mac_widx  <= r_tap_widx;
            r_wcap_en   <= r_w_rd_en;
            r_wcap_idx  <= r_w_addr;
        end
    end

    always_ff @(posedge clk_a) begin
        if (r_wcap_en)
            r_wrf[r_wcap_idx] <= mem.w_rdata;
    end

    cnnip_mac u_mac (
        .i_clk  (clk_a),
        .i_rst  (rst_aq),
        .i_en   (r_mac_vld),
        .i_clr  (r_mac_first),
        .i_zero (r_mac_zero),
        .i_pix  (mem.in_rdata),
        .i_w    (r_wrf[r_mac_widx]),
        .o_acc  (w_acc)
    );

    assign mem.in_rd_en = r_in_rd_en;
    assign mem.in_addr  = r_in_addr;
    assign mem.w_rd_en  = r_w_rd_en;
    assign mem.w_addr   = r_w_addr;
    assign mem.ft_wr_en = r_ft_wr_en;
    assign mem.ft_addr  = r_ft_addr;
    assign mem.ft_wdata = r_ft_wr_en
        ? {{(ACC_W-SUM_W){w_acc[SUM_W-1]}}, w_acc} : '0;
    assign CONV_end = r_end;
    assign CONV_err = r_err;
    assign busy     = r_busy;
endmodule

// File: tb/tb_cnnip_conv_engine.sv
// Bench for cnnip_conv_engine: directed modes plus random data vs a loop model.
module tb_cnnip_conv_engine;
    import cnnip_pkg::*;

    logic       clk_a = 1'b0;
    logic       rst_aq = 1'b1;
    logic       CONV_start = 1'b0;
    logic [7:0] MODE_KERNEL_SIZE = 8'd0;
    logic [1:0] MODE_STRIDE = 2'd0;
    logic       MODE_PADDING = 1'b0;
    logic       CONV_end, CONV_err, busy;

    cnnip_conv_engine_if mif();

    cnnip_conv_engine dut (
        .clk_a            (clk_a),
        .rst_aq           (rst_aq),
        .CONV_start       (CONV_start),
        .MODE_KERNEL_SIZE (MODE_KERNEL_SIZE),
        .MODE_STRIDE      (MODE_STRIDE),
        .MODE_PADDING     (MODE_PADDING),
        .mem              (mif),
        .CONV_end         (CONV_end),
        .CONV_err         (CONV_err),
        .busy             (busy)
    );

    always #5 clk_a = ~clk_a;

    logic [7:0]  in_mem [256];
    logic [7:0]  w_mem  [32];
    logic [31:0] ft_mem [256];
    logic [31:0] exp_ft [256];
    int n_vec = 0;
    int n_miss = 0;
    int exp_n, exp_rd, exp_end;
    bit exp_err;

    always @(posedge clk_a) begin
        if (mif.in_rd_en) mif.in_rdata <= in_mem[mif.in_addr];
        if (mif.w_rd_en)  mif.w_rdata  <= w_mem[mif.w_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 256; i++) in_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 32; i++)  w_mem[i]  = 8'($urandom);
    endtask

    // Direct 2-D convolution over the image with zero padding.
    task automatic model(input int k, input int s, input int p);
        int pp, acc, iy, ix;
        bit legal;
        legal = (k == 1 || k == 3 || k == 5) && (s == 1 || s == 2);
        if (!legal) begin
            exp_n = 0; exp_rd = 0; exp_end = 1; exp_err = 1'b1;
            return;
        end
        pp = p ? (k - 1) / 2 : 0;
        exp_n = p ? (IMG_W + s - 1) / s : (IMG_W - k) / s + 1;
        exp_rd = 0;
        for (int oy = 0; oy < exp_n; oy++)
            for (int ox = 0; ox < exp_n; ox++) begin
                acc = 0;
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        iy = oy * s - pp + ky;
                        ix = ox * s - pp + kx;
                        if (iy >= 0 && iy < IMG_W && ix >= 0 && ix < IMG_W) begin
                            acc += int'(in_mem[iy * IMG_W + ix])
                                 * int'($signed(w_mem[ky * k + kx]));
                            exp_rd++;
                        end
                    end
                exp_ft[oy * exp_n + ox] = acc;
            end
        exp_end = 1 + (k * k + 1) + exp_n * exp_n * (k * k + 2);
        exp_err = 1'b0;
    endtask

    task automatic run(input int k, input int s, input int p,
                       input int rst_at, input int glitch_at,
                       output int end_c);
        int wr_n = 0;
        int rd_n = 0;
        int wrd_n = 0;
        int ovl = 0;
        int quiet = 0;
        int budget;
        bit err_v = 1'b0;
        model(k, s, p);
        budget = exp_end + 20;
        end_c = -1;
        @(negedge clk_a);
        MODE_KERNEL_SIZE = 8'(k);
        MODE_STRIDE = 2'(s);
        MODE_PADDING = 1'(p);
        CONV_start = 1'b1;
        @(posedge clk_a);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk_a);
            if (c == 1) CONV_start = 1'b0;
            if (int'(mif.in_rd_en) + int'(mif.w_rd_en) + int'(mif.ft_wr_en) > 1)
                ovl++;
            if (mif.in_rd_en) rd_n++;
            if (mif.w_rd_en) wrd_n++;
            if (mif.ft_wr_en) begin
                ft_mem[mif.ft_addr] = mif.ft_wdata;
                if (rst_at == 0)
                    chk($sformatf("wr%0d", wr_n),
                        64'({mif.ft_addr, mif.ft_wdata}),
                        64'({8'(wr_n), exp_ft[wr_n % 256]}));
                wr_n++;
            end
            if (glitch_at != 0 && c == glitch_at) begin
                CONV_start = 1'b1;
                MODE_KERNEL_SIZE = 8'd5;
                MODE_STRIDE = 2'd2;
                MODE_PADDING = ~MODE_PADDING;
            end
            if (glitch_at != 0 && c == glitch_at + 1) CONV_start = 1'b0;
            if (c == rst_at) begin
                rst_aq = 1'b1;
                break;
            end
            if (CONV_end) begin
                end_c = c;
                err_v = CONV_err;
                break;
            end
        end
        if (rst_at != 0) begin
            @(negedge clk_a);
            chk("rst_quiet", 64'({mif.in_rd_en, mif.w_rd_en, mif.ft_wr_en,
                                  busy, CONV_end}), 64'(0));
            rst_aq = 1'b0;
            repeat (8) begin
                @(negedge clk_a);
                if (mif.in_rd_en || mif.w_rd_en || mif.ft_wr_en || busy)
                    quiet++;
            end
            chk("rst_idle", 64'(quiet), 64'(0));
            return;
        end
        chk("end_cycle", 64'(end_c), 64'(exp_end));
        chk("end_err", 64'(err_v), 64'(exp_err));
        chk("wr_count", 64'(wr_n), 64'(exp_n * exp_n));
        chk("in_rd_count", 64'(rd_n), 64'(exp_rd));
        chk("w_rd_count", 64'(wrd_n), 64'(exp_err ? 0 : k * k));
        chk("strobe_overlap", 64'(ovl), 64'(0));
        @(negedge clk_a);
        chk("end_pulse", 64'({CONV_end, busy}), 64'(0));
    endtask

    initial begin
        int e;
        rst_aq = 1'b1;
        repeat (3) @(negedge clk_a);
        chk("reset_state",
            64'({mif.in_rd_en, mif.in_addr, mif.w_rd_en, mif.w_addr,
                 mif.ft_wr_en, mif.ft_addr, mif.ft_wdata,
                 CONV_end, CONV_err, busy}), 64'(0));
        rst_aq = 1'b0;

        rand_mem();
        for (int a = 0; a < 256; a++) in_mem[a] = 8'(a % 128);
        w_mem[0] = 8'd2;
        run(1, 1, 0, 0, 0, e);
        chk("t1_end", 64'(e), 64'(771));
        chk("t1_ft200", 64'(ft_mem[200]), 64'(144));

        for (int a = 0; a < 256; a++) in_mem[a] = 8'd1;
        for (int i = 0; i < 32; i++) w_mem[i] = 8'd1;
        run(3, 1, 1, 0, 0, e);
        chk("t2_ft0", 64'(ft_mem[0]), 64'(4));
        chk("t2_ft1", 64'(ft_mem[1]), 64'(6));
        chk("t2_ft17", 64'(ft_mem[17]), 64'(9));
        chk("t2_ft255", 64'(ft_mem[255]), 64'(4));

        for (int a = 0; a < 256; a++) in_mem[a] = 8'd255;
        for (int i = 0; i < 32; i++) w_mem[i] = 8'hFF;
        run(5, 2, 0, 0, 0, e);
        chk("t3_end", 64'(e), 64'(999));
        chk("t3_ft35", 64'(ft_mem[35]), 64'(32'hFFFFE719));

        run(4, 1, 0, 0, 0, e);
        chk("k4_end", 64'(e), 64'(1));
        run(3, 0, 1, 0, 0, e);

        foreach (w_mem[i]) ;
        for (int k = 1; k <= 5; k += 2)
            for (int s = 1; s <= 2; s++)
                for (int p = 0; p <= 1; p++) begin
                    rand_mem();
                    run(k, s, p, 0, 0, e);
                end

        rand_mem();
        run(3, 1, 1, 40, 0, e);
        run(3, 1, 1, 0, 0, e);

        rand_mem();
        run(3, 2, 1, 0, 30, e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/cnnip_conv_engine.md
# cnnip_conv_engine

Convolution datapath sequencer directly downstream of the CNN IP controller. When the controller enters CONV it pulses `CONV_start`. The engine then:
- reads the 16x16 input image from input memory and the KxK kernel from weight memory;
- computes a single-channel 2-D convolution with the latched stride and padding;
- writes one 32-bit result per output pixel into feature memory;
- pulses `CONV_end` back to the controller.

## Interface
- `IMG_W`, 16, input image width and height in pixels (address = y*IMG_W+x)
- `ACC_W`, 32, feature word width; accumulator sign-extended to this width
- `clk_a`  in  1  single clock; all logic rising-edge
- `rst_aq`  in  1  reset, synchronous, active-high
- `CONV_start`  in  1  start pulse from controller; sampled only in IDLE
- `MODE_KERNEL_SIZE`  in  8  K; legal values 1, 3, 5
- `MODE_STRIDE`  in  2  S; legal values 1, 2
- `MODE_PADDING`  in  1  1 = zero-pad P=(K-1)/2 on every side, 0 = P=0
- `in_rd_en`  out  1  input memory read strobe
- `in_addr`  out  8  input memory address
- `in_rdata`  in  8  unsigned pixel, valid the cycle after `in_rd_en`
- `w_rd_en`  out  1  weight memory read strobe
- `w_addr`  out  5  weight address ky*K+kx
- `w_rdata`  in  8  signed weight, valid the cycle after `w_rd_en`
- `ft_wr_en`  out  1  feature memory write strobe
- `ft_addr`  out  8  feature address oy*N+ox
- `ft_wdata`  out  ACC_W  signed convolution result
- `CONV_end`  out  1  one-cycle done pulse
- `CONV_err`  out  1  qualifies `CONV_end`; 1 = illegal mode, nothing computed
- `busy`  out  1  high in every state except IDLE

## Operation
- Mode latch:
  - K, S and P are captured on the accepted `CONV_start`.
  - Mode inputs are ignored until the engine is back in IDLE.
  - `CONV_start` outside IDLE is ignored.
- Output dimension N:
  - P=0: N=(IMG_W-K)/S+1.
  - P>0: N=ceil(IMG_W/S).
  - Examples: K=5,S=1,P=0 gives 12; K=3,S=2,pad gives 8.
- FSM: IDLE → LOAD_W → MAC → ACC_LAST → WR → (MAC | DONE) → IDLE.
  - IDLE: on start, go to LOAD_W with legal mode, otherwise go to DONE with error.
  - LOAD_W: issues K*K weight reads on consecutive cycles, addresses 0..K*K-1. Each returned weight is stored in a 25-entry signed register file one cycle later. The state lasts K*K+1 cycles.
  - MAC: one tap per cycle, row-major (ky outer, kx inner), K*K cycles.
    - Tap coordinates: iy=oy*S-P+ky, ix=ox*S-P+kx.
    - In bounds: issue `in_rd_en` with address iy*IMG_W+ix.
    - Out of bounds: no read; a zero operand is forwarded through the same one-cycle pipeline slot.
    - The accumulator is cleared on the first tap of each pixel.
  - ACC_LAST: accumulates the last product; no memory activity.
  - WR: `ft_wr_en`=1 with address oy*N+ox and data equal to the sign-extended accumulator. Then advance ox, wrapping to 0 and incrementing oy. After pixel (N-1,N-1), go to DONE.
  - DONE: `CONV_end`=1 for exactly one cycle, `CONV_err` per the mode check, then IDLE.
- Arithmetic:
  - Product = unsigned 8-bit pixel × signed 8-bit weight (17-bit signed).
  - Sum of up to 25 products fits in 22 bits signed; no saturation, no ReLU.
- Illegal mode: K∉{1,3,5} or S∉{1,2}. The engine performs no memory strobes and reaches DONE with `CONV_err`=1.

## Timing
- Reset values: all strobes 0, addresses 0, `ft_wdata` 0, `CONV_end` 0, `CONV_err` 0, `busy` 0, FSM IDLE.
- Reset asserted mid-operation: the engine is in IDLE on the next cycle and no strobe is issued after that edge. Partial feature contents are left as written.
- Read latency from memories is exactly 1 cycle; the engine never stalls.
- Cycle numbering: `CONV_start` sampled at cycle 0, LOAD_W begins at cycle 1.
  - Each output pixel takes K*K+2 cycles.
  - `CONV_end` is high at cycle 1+(K*K+1)+N*N*(K*K+2).
  - Illegal mode: `CONV_end` is high at cycle 1.
- At most one of `in_rd_en`, `w_rd_en`, `ft_wr_en` is high in any cycle.
- Feature writes are strictly ascending in address, one per pixel.

## Structure
- Shared package `cnnip_pkg` holds:
  - `IMG_W`, `K_MAX`=5, `ACC_W`;
  - the state enum `conv_state_t` (IDLE, LOAD_W, MAC, ACC_LAST, WR, DONE);
  - the legal-mode check function and the N computation function.
- One sub-module `cnnip_mac`: 1-cycle registered multiply-accumulate with clear-on-first and zero-operand input. Address generation and the FSM stay in the top module.

## Test plan
- K=1,S=1,P=0, w[0]=2, input[a]=a mod 128 → 256 writes, feature[a]=2*(a mod 128), `CONV_end` at cycle 771, `CONV_err`=0.
- K=3,S=1,pad, all weights 1, all pixels 1 → N=16. Results: feature[0]=4, feature[1]=6, feature[17]=9, feature[255]=4. No `in_rd_en` at an out-of-bounds tap.
- K=5,S=2,P=0, weights 0xFF (−1), pixels 255 → N=6, 36 writes of −6375 (0xFFFFE719), `CONV_end` at cycle 999.
- `MODE_KERNEL_SIZE`=4 (or `MODE_STRIDE`=0) → `CONV_end`=`CONV_err`=1 at cycle 1, zero memory strobes.
- `rst_aq` pulsed mid-MAC → no strobes afterwards, `busy`=0. Restart with the same mode gives results identical to an uninterrupted run.
- `CONV_start` re-pulsed while `busy`, mode inputs changed mid-run → ignored: write count, data and `CONV_end` timing unchanged.
